uart_rx_ctrl: RTL and testbench

//  CPU-facing controller for the UART receiver: gates receiver enable, buffers received bytes in a FIFO,

---
 rtl/arch_defs_pkg.sv | 31 +++
 rtl/sync_fifo.sv | 55 +++++
 rtl/uart_rx_ctrl.sv | 170 +++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arch_defs_pkg.sv
// Shared definitions for the UART receive controller.
//   DATA_WIDTH        byte width carried from receiver to CPU
//   uart_rxc_state_t  controller FSM states
//   UART_RXC_ADDR_*   peripheral register addresses
//   ST_* / CT_*       bit positions inside STATUS and CONTROL
package arch_defs_pkg;

    localparam int DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        S_RXC_DISABLED = 2'd0,
        S_RXC_ACTIVE   = 2'd1,
        S_RXC_DRAIN    = 2'd2,
        S_RXC_FLUSH    = 2'd3
    } uart_rxc_state_t;

    localparam logic [1:0] UART_RXC_ADDR_DATA    = 2'd0;
    localparam logic [1:0] UART_RXC_ADDR_STATUS  = 2'd1;
    localparam logic [1:0] UART_RXC_ADDR_CONTROL = 2'd2;

    localparam int ST_AVAIL   = 0;
    localparam int ST_FULL    = 1;
    localparam int ST_OVERRUN = 2;
    localparam int ST_FRAME   = 3;
    localparam int ST_IRQ     = 4;

    localparam int CT_RX_EN  = 0;
    localparam int CT_IRQ_EN = 1;
    localparam int CT_FLUSH  = 2;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous flush.
// Ports: clk, reset_n (async low); push/pop/flush controls; wdata in;
//        rdata = current head (combinational); full, empty, count.
// A push while full succeeds only when a pop happens in the same cycle.
// A pop while empty is ignored.
module sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// CPU-side controller for the UART receiver.
// Ports: clk, reset_n (async low); receiver side rx_strobe/rx_frame_err/
//        rx_busy/rx_byte in, rx_enable out; bus side cs/rd_en/wr_en/addr/
//        bus_wdata in, bus_rdata out (registered); irq out.
// Registers: 0 DATA (pop FIFO head), 1 STATUS (W1C overrun/frame_err),
//            2 CONTROL (rx_en, irq_en, self-clearing flush), 3 reserved.
// Build option: define UART_RX_CTRL_IRQ_EN to enable the interrupt; when it
// is undefined irq, STATUS[4] and CONTROL[1] all read as 0.
module uart_rx_ctrl
    import arch_defs_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  rx_strobe,
    input  logic                  rx_frame_err,
    input  logic                  rx_busy,
    input  logic [DATA_WIDTH-1:0] rx_byte,
    output logic                  rx_enable,
    input  logic                  cs,
    input  logic                  rd_en,
    input  logic                  wr_en,
    input  logic [1:0]            addr,
    input  logic [DATA_WIDTH-1:0] bus_wdata,
    output logic [DATA_WIDTH-1:0] bus_rdata,
    output logic                  irq
);
    uart_rxc_state_t state, state_nxt;

    logic                        rx_en_q, ovr_q, ferr_q, irq_en_bit, irq_bit;
    logic                        bus_rd, bus_wr, ctrl_wr, stat_wr, flush_wr;
    logic                        rx_live, push, pop, ovr_evt, ferr_evt;
    logic                        fifo_full, fifo_empty;
    logic [DATA_WIDTH-1:0]       fifo_head, status_val, rd_mux;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;

    // A write in the same cycle as a read wins; the read is dropped.
    assign bus_rd   = cs && rd_en && !wr_en;
    assign bus_wr   = cs && wr_en;
    assign ctrl_wr  = bus_wr && (addr == UART_RXC_ADDR_CONTROL);
    assign stat_wr  = bus_wr && (addr == UART_RXC_ADDR_STATUS);
    assign flush_wr = ctrl_wr && bus_wdata[CT_FLUSH];

    assign rx_live  = (state == S_RXC_ACTIVE) || (state == S_RXC_DRAIN);
    assign push     = rx_strobe && rx_live;
    assign pop      = bus_rd && (addr == UART_RXC_ADDR_DATA);
    // Full implies non-empty, so any DATA read frees a slot this cycle.
    assign ovr_evt  = push && fifo_full && !pop;
    assign ferr_evt = rx_frame_err && rx_live;

    sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_WIDTH)) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .pop     (pop),
        .flush   (state == S_RXC_FLUSH),
        .wdata   (rx_byte),
        .rdata   (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // ---- FSM: state register ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_RXC_DISABLED;
        else          state <= state_nxt;
    end

    // ---- FSM: next state ----
    always_comb begin
        state_nxt = state;
        if (flush_wr) begin
            state_nxt = S_RXC_FLUSH;
        end else begin
            case (state)
                S_RXC_DISABLED:
                    if (ctrl_wr && bus_wdata[CT_RX_EN]) state_nxt = S_RXC_ACTIVE;
                S_RXC_ACTIVE:
                    if (ctrl_wr && !bus_wdata[CT_RX_EN])
                        state_nxt = rx_busy ? S_RXC_DRAIN : S_RXC_DISABLED;
                S_RXC_DRAIN:
                    if (ctrl_wr && bus_wdata[CT_RX_EN])            state_nxt = S_RXC_ACTIVE;
                    else if (rx_strobe || rx_frame_err || !rx_busy) state_nxt = S_RXC_DISABLED;
                S_RXC_FLUSH: begin
                    // Honour a CONTROL write landing on the flush cycle itself.
                    if (ctrl_wr ? bus_wdata[CT_RX_EN] : rx_en_q) state_nxt = S_RXC_ACTIVE;
                    else                                         state_nxt = S_RXC_DISABLED;
                end
                default: state_nxt = S_RXC_DISABLED;
            endcase
        end
    end

    // ---- FSM: outputs ----
    // During FLUSH keep the receiver as configured so a frame in flight survives.
    always_comb begin
        rx_enable = 1'b0;
        case (state)
            S_RXC_ACTIVE, S_RXC_DRAIN: rx_enable = 1'b1;
            S_RXC_FLUSH:               rx_enable = rx_en_q;
            default:                   rx_enable = 1'b0;
        endcase
    end

    // ---- registers and sticky flags (a new event beats a same-cycle clear) ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_en_q <= 1'b0;
            ovr_q   <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            if (ctrl_wr) rx_en_q <= bus_wdata[CT_RX_EN];
            ovr_q  <= ovr_evt  || (ovr_q  && !(stat_wr && bus_wdata[ST_OVERRUN]));
            ferr_q <= ferr_evt || (ferr_q && !(stat_wr && bus_wdata[ST_FRAME]));
        end
    end

`ifdef UART_RX_CTRL_IRQ_EN
    logic irq_en_q, irq_q;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            if (ctrl_wr) irq_en_q <= bus_wdata[CT_IRQ_EN];
            irq_q <= irq_en_q && (!fifo_empty || ovr_q || ferr_q);
        end
    end
    assign irq_en_bit = irq_en_q;
    assign irq_bit    = irq_q;
`else
    assign irq_en_bit = 1'b0;
    assign irq_bit    = 1'b0;
`endif
    assign irq = irq_bit;

    // ---- bus read mux; STATUS reflects flags before this cycle's update ----
    always_comb begin
        status_val             = '0;
        status_val[ST_AVAIL]   = !fifo_empty;
        status_val[ST_FULL]    = fifo_full;
        status_val[ST_OVERRUN] = ovr_q;
        status_val[ST_FRAME]   = ferr_q;
        status_val[ST_IRQ]     = irq_bit;
    end

    always_comb begin
        rd_mux = '0;
        case (addr)
            UART_RXC_ADDR_DATA:    rd_mux = fifo_empty ? '0 : fifo_head;
            UART_RXC_ADDR_STATUS:  rd_mux = status_val;
            UART_RXC_ADDR_CONTROL: begin
                rd_mux[CT_RX_EN]  = rx_en_q;
                rd_mux[CT_IRQ_EN] = irq_en_bit;
            end
            default:               rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)    bus_rdata <= '0;
        else if (bus_rd) bus_rdata <= rd_mux;
    end

    logic unused_bits;
    assign unused_bits = ^{bus_wdata, fifo_count};

endmodule

// File: tb/tb_uart_rx_ctrl.sv
module tb_uart_rx_ctrl;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       rx_strobe = 1'b0, rx_frame_err = 1'b0, rx_busy = 1'b0;
    logic [7:0] rx_byte = '0;
    logic       rx_enable;
    logic       cs = 1'b0, rd_en = 1'b0, wr_en = 1'b0;
    logic [1:0] addr = '0;
    logic [7:0] bus_wdata = '0;
    logic [7:0] bus_rdata;
    logic       irq;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    uart_rx_ctrl #(.FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n),
        .rx_strobe(rx_strobe), .rx_frame_err(rx_frame_err), .rx_busy(rx_busy),
        .rx_byte(rx_byte), .rx_enable(rx_enable),
        .cs(cs), .rd_en(rd_en), .wr_en(wr_en), .addr(addr),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .irq(irq)
    );

    // Reference model: byte queue plus sticky flags.
    logic [7:0] mq[$];
    bit         m_ovr, m_ferr;

    function automatic logic [7:0] m_status();
        return {3'b000, 1'b0, m_ferr, m_ovr, (mq.size() == DEPTH), (mq.size() != 0)};
    endfunction

    // ---- stimulus helpers (no checking) ----
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        cs = 1; wr_en = 1; addr = a; bus_wdata = d;
        @(negedge clk);
        cs = 0; wr_en = 0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
        @(negedge clk);
        cs = 1; rd_en = 1; addr = a;
        @(negedge clk);
        cs = 0; rd_en = 0;
        d = bus_rdata;
    endtask

    task automatic strobe(input logic [7:0] b);
        @(negedge clk);
        rx_strobe = 1; rx_byte = b;
        @(negedge clk);
        rx_strobe = 0;
    endtask

    task automatic frame_err_pulse();
        @(negedge clk);
        rx_frame_err = 1;
        @(negedge clk);
        rx_frame_err = 0;
    endtask

    // ---- scenarios ----
    task automatic test_reset();
        logic [7:0] d;
        idle(2);
        n_total++; if (rx_enable !== 1'b0) $display("FAIL reset_rx_enable got %b exp 0", rx_enable); else n_pass++;
        n_total++; if (bus_rdata !== 8'h00) $display("FAIL reset_rdata got %h exp 00", bus_rdata); else n_pass++;
        n_total++; if (irq !== 1'b0) $display("FAIL reset_irq got %b exp 0", irq); else n_pass++;
        reset_n = 1;
        bus_read(2'd1, d);
        n_total++; if (d !== 8'h00) $display("FAIL reset_status got %h exp 00", d); else n_pass++;
        bus_read(2'd2, d);
        n_total++; if (d !== 8'h00) $display("FAIL reset_control got %h exp 00", d); else n_pass++;
    endtask

    task automatic test_basic();
        logic [7:0] d, b;
        b = 8'($urandom);
        bus_write(2'd2, 8'h01);
        n_total++; if (rx_enable !== 1'b1) $display("FAIL basic_rx_enable got %b exp 1", rx_enable); else n_pass++;
        strobe(b);
        bus_read(2'd1, d);
        n_total++; if (d !== 8'h01) $display("FAIL basic_status got %h exp 01", d); else n_pass++;
        bus_read(2'd0, d);
        n_total++; if (d !== b) $display("FAIL basic_data got %h exp %h", d, b); else n_pass++;
        bus_read(2'd1, d);
        n_total++; if (d !== 8'h00) $display("FAIL basic_status_empty got %h exp 00", d); else n_pass++;
    endtask

    task automatic test_fill_overrun();
        logic [7:0] d, base;
        base = 8'($urandom_range(0, 250));
        for (int i = 0; i < 5; i++) strobe(base + 8'(i));
        bus_read(2'd1, d);
        n_total++; if (d !== 8'h07) $display("FAIL fill_status got %h exp 07", d); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            bus_read(2'd0, d);
            n_total++; if (d !== base + 8'(i)) $display("FAIL fill_data%0d got %h exp %h", i, d, base + 8'(i)); else n_pass++;
        end
        bus_read(2'd0, d);
        n_total++; if (d !== 8'h00) $display("FAIL fill_empty_data got %h exp 00", d); else n_pass++;
        bus_write(2'd1, 8'h04);
        bus_read(2'd1, d);
        n_total++; if (d !== 8'h00) $display("FAIL fill_ovr_clear got %h exp 00", d); else n_pass++;
    endtask

    task automatic test_push_pop_full();
        logic [7:0] d;
        logic [7:0] b[5];
        for (int i = 0; i < 5; i++) b[i] = 8'($urandom);
        for (int i = 0; i < 4; i++) strobe(b[i]);
        @(negedge clk);
        rx_strobe = 1; rx_byte = b[4]; cs = 1; rd_en = 1; addr = 2'd0;
        @(negedge clk);
        rx_strobe = 0; cs = 0; rd_en = 0;
        n_total++; if (bus_rdata !== b[0]) $display("FAIL pp_full_data got %h exp %h", bus_rdata, b[0]); else n_pass++;
        bus_read(2'd1, d);
        n_total++; if (d !== 8'h03) $display("FAIL pp_full_status got %h exp 03", d); else n_pass++;
        for (int i = 1; i < 5; i++) begin
            bus_read(2'd0, d);
            n_total++; if (d !== b[i]) $display("FAIL pp_full_drain%0d got %h exp %h", i, d, b[i]); else n_pass++;
        end
    endtask

    task automatic test_frame_err();
        logic [7:0] d, b;
        b = 8'($urandom);
        strobe(b);
        frame_err_pulse();
        bus_read(2'd1, d);
        n_total++; if (d !== 8'h09) $display("FAIL ferr_status got %h exp 09", d); else n_pass++;
        bus_write(2'd1, 8'h08);
        bus_read(2'd1, d);
        n_total++; if (d !== 8'h01) $display("FAIL ferr_cleared got %h exp 01", d); else n_pass++;
        bus_read(2'd0, d);
        n_total++; if (d !== b) $display("FAIL ferr_data got %h exp %h", d, b); else n_pass++;
    endtask

    task automatic test_flush();
        logic [7:0] d;
        for (int i = 0; i < 3; i++) strobe(8'($urandom));
        frame_err_pulse();
        bus_write(2'd2, 8'h05);
        n_total++; if (rx_enable !== 1'b1) $display("FAIL flush_rx_enable got %b exp 1", rx_enable); else n_pass++;
        idle(3);
        bus_read(2'd1, d);
        n_total++; if (d !== 8'h08) $display("FAIL flush_status got %h exp 08", d); else n_pass++;
        bus_read(2'd2, d);
        n_total++; if (d !== 8'h01) $display("FAIL flush_control got %h exp 01", d); else n_pass++;
        bus_read(2'd0, d);
        n_total++; if (d !== 8'h00) $display("FAIL flush_data got %h exp 00", d); else n_pass++;
        bus_write(2'd1, 8'h08);
        bus_read(2'd1, d);
        n_total++; if (d !== 8'h00) $display("FAIL flush_clear got %h exp 00", d); else n_pass++;
    endtask

    task automatic test_reserved();
        logic [7:0] d;
        bus_write(2'd3, 8'hFF);
        bus_read(2'd3, d);
        n_total++; if (d !== 8'h00) $display("FAIL reserved got %h exp 00", d); else n_pass++;
        bus_read(2'd2, d);
        n_total++; if (d !== 8'h01) $display("FAIL reserved_ctrl got %h exp 01", d); else n_pass++;
    endtask

    task automatic test_random();
        bit         pend = 0;
        logic [7:0] exp_rd = '0;
        int         op;
        bit         s, fe, pop, wr;
        logic [7:0] w;
        mq.delete(); m_ovr = 0; m_ferr = 0;
        for (int i = 0; i <= 400; i++) begin
            @(negedge clk);
            if (pend) begin
                n_total++;
                if (bus_rdata !== exp_rd) $display("FAIL random_cyc%0d got %h exp %h", i, bus_rdata, exp_rd);
                else n_pass++;
            end
            rx_strobe = 0; rx_frame_err = 0; cs = 0; rd_en = 0; wr_en = 0;
            pend = 0; pop = 0; wr = 0; s = 0; fe = 0; w = '0;
            if (i == 400) break;
            op = $urandom_range(0, 9);
            if (op == 4 || op == 5) begin
                cs = 1; rd_en = 1; addr = 2'd0;
                pend = 1; pop = 1;
                exp_rd = (mq.size() != 0) ? mq[0] : 8'h00;
            end else if (op == 6) begin
                cs = 1; rd_en = 1; addr = 2'd1;
                pend = 1; exp_rd = m_status();
            end else if (op == 7) begin
                w = 8'($urandom);
                cs = 1; wr_en = 1; addr = 2'd1; bus_wdata = w; wr = 1;
            end
            s  = ($urandom_range(0, 9) < 4);
            fe = !s && !wr && ($urandom_range(0, 19) == 0);
            rx_strobe = s; rx_frame_err = fe; rx_byte = 8'($urandom);
            // model update for this edge
            if (wr) begin
                if (w[2]) m_ovr = 0;
                if (w[3]) m_ferr = 0;
            end
            if (pop && mq.size() != 0) void'(mq.pop_front());
            if (s) begin
                if (mq.size() < DEPTH) mq.push_back(rx_byte);
                else m_ovr = 1;
            end
            if (fe) m_ferr = 1;
        end
        // drain and clear so later scenarios start clean
        for (int i = 0; i < DEPTH; i++) begin
            logic [7:0] d;
            bus_read(2'd0, d);
        end
        bus_write(2'd1, 8'h0C);
    endtask

    task automatic test_drain();
        logic [7:0] d, b;
        b = 8'($urandom);
        rx_busy = 1;
        bus_write(2'd2, 8'h00);
        n_total++; if (rx_enable !== 1'b1) $display("FAIL drain_rx_enable got %b exp 1", rx_enable); else n_pass++;
        strobe(b);
        n_total++; if (rx_enable !== 1'b0) $display("FAIL drain_done got %b exp 0", rx_enable); else n_pass++;
        rx_busy = 0;
        bus_read(2'd0, d);
        n_total++; if (d !== b) $display("FAIL drain_data got %h exp %h", d, b); else n_pass++;
        strobe(8'($urandom));
        bus_read(2'd1, d);
        n_total++; if (d !== 8'h00) $display("FAIL disabled_ignore got %h exp 00", d); else n_pass++;
    endtask

    task automatic test_irq();
        logic [7:0] d;
        bus_write(2'd2, 8'h03);
`ifdef UART_RX_CTRL_IRQ_EN
        bus_read(2'd2, d);
        n_total++; if (d !== 8'h03) $display("FAIL irq_control got %h exp 03", d); else n_pass++;
        strobe(8'($urandom));
        @(negedge clk);
        n_total++; if (irq !== 1'b1) $display("FAIL irq_set got %b exp 1", irq); else n_pass++;
        bus_read(2'd1, d);
        n_total++; if (d !== 8'h11) $display("FAIL irq_status got %h exp 11", d); else n_pass++;
        bus_read(2'd0, d);
        idle(2);
        n_total++; if (irq !== 1'b0) $display("FAIL irq_clear got %b exp 0", irq); else n_pass++;
        strobe(8'($urandom));
        bus_write(2'd2, 8'h07);
        idle(3);
        bus_read(2'd1, d);
        n_total++; if (d !== 8'h00) $display("FAIL irq_flush_status got %h exp 00", d); else n_pass++;
`else
        bus_read(2'd2, d);
        n_total++; if (d !== 8'h01) $display("FAIL irq_control got %h exp 01", d); else n_pass++;
        strobe(8'($urandom));
        idle(2);
        n_total++; if (irq !== 1'b0) $display("FAIL irq_tied got %b exp 0", irq); else n_pass++;
        bus_read(2'd1, d);
        n_total++; if (d !== 8'h01) $display("FAIL irq_status got %h exp 01", d); else n_pass++;
        bus_read(2'd0, d);
`endif
    endtask

    task automatic test_reset_mid();
        logic [7:0] d;
        strobe(8'($urandom));
        strobe(8'($urandom));
        @(negedge clk);
        cs = 1; rd_en = 1; addr = 2'd0;
        #2 reset_n = 0;
        #1;
        n_total++; if (rx_enable !== 1'b0) $display("FAIL rstmid_rx_enable got %b exp 0", rx_enable); else n_pass++;
        n_total++; if (bus_rdata !== 8'h00) $display("FAIL rstmid_rdata got %h exp 00", bus_rdata); else n_pass++;
        @(negedge clk);
        cs = 0; rd_en = 0;
        @(negedge clk);
        reset_n = 1;
        bus_read(2'd1, d);
        n_total++; if (d !== 8'h00) $display("FAIL rstmid_status got %h exp 00", d); else n_pass++;
        bus_read(2'd2, d);
        n_total++; if (d !== 8'h00) $display("FAIL rstmid_control got %h exp 00", d); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_fill_overrun();
        test_push_pop_full();
        test_frame_err();
        test_flush();
        test_reserved();
        test_random();
        test_drain();
        test_irq();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
